rtc_access_sequencer: RTL and testbench

// - Bus master for the multiplexed address/data RTC port: sequences every RTC access as address phase, gap, data phase, gap.
// - After reset it runs the init writes, then periodically sweeps the nine time/timer registers into shadow copies.
// - Accepts user write requests from the config logic and interleaves them between sweep accesses.
// - Addresses/constants come from the shared register table; this block decides order and timing only.

---
 rtl/rtc_pkg.sv | 38 +++
 rtl/rtc_bus_phy.sv | 106 ++++++++++
 rtl/rtc_access_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_rtc_access_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared register table, init constants and state encodings for the RTC access sequencer.
// Table index = register-table index: 0..8 time/timer registers, 9 command, 10 status.
package rtc_pkg;

    localparam logic [3:0] IDX_LAST_TIME = 4'd8;
    localparam logic [3:0] IDX_STATUS    = 4'd10;

    localparam logic [0:10][7:0] RTC_ADDR = {
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
        8'h41, 8'h42, 8'h43,
        8'hF0,
        8'h02
    };

    localparam logic [7:0] INIT_VAL = 8'h10;
    localparam logic [7:0] ZERO_VAL = 8'h00;

    typedef enum logic [2:0] {
        PHY_IDLE,
        PHY_ADR,
        PHY_GAP1,
        PHY_DAT,
        PHY_GAP2
    } phy_state_t;

    typedef enum logic [1:0] {
        SCH_INIT0,
        SCH_INIT1,
        SCH_RUN
    } sched_state_t;

    typedef enum logic [1:0] {
        ACC_INIT,
        ACC_USER,
        ACC_SWEEP
    } acc_kind_t;

endpackage

// File: rtl/rtc_bus_phy.sv
// One RTC bus access: address phase, gap, data phase, gap, each T_PHASE cycles (4*T_PHASE total).
// Takes i_start only while idle; o_dat_end marks the last data-phase cycle, o_done the last gap cycle.
module rtc_bus_phy
    import rtc_pkg::*;
#(
    parameter int T_PHASE = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_rnw,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_idle,
    output logic       o_dat_end,
    output logic       o_done,
    output logic [7:0] o_ad_out,
    output logic       o_ad_oe,
    output logic       o_cs_n,
    output logic       o_rd_n,
    output logic       o_wr_n,
    output logic       o_a_d
);

    localparam int             CW      = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0]  PH_LAST = CW'(T_PHASE - 1);

    phy_state_t    r_state;
    phy_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic          r_rnw;
    logic [7:0]    r_addr;
    logic [7:0]    r_data;
    logic          w_phase_end;

    assign w_phase_end = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= PHY_IDLE;
            r_cnt   <= '0;
            r_rnw   <= 1'b0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            // Reload on every phase change so each phase lasts exactly T_PHASE cycles.
            if (r_state != w_next) begin
                r_cnt <= PH_LAST;
            end else if (!w_phase_end) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == PHY_IDLE && i_start) begin
                r_rnw  <= i_rnw;
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PHY_IDLE: if (i_start)     w_next = PHY_ADR;
            PHY_ADR:  if (w_phase_end) w_next = PHY_GAP1;
            PHY_GAP1: if (w_phase_end) w_next = PHY_DAT;
            PHY_DAT:  if (w_phase_end) w_next = PHY_GAP2;
            PHY_GAP2: if (w_phase_end) w_next = PHY_IDLE;
            default:                   w_next = PHY_IDLE;
        endcase
    end

    always_comb begin
        o_cs_n   = 1'b1;
        o_rd_n   = 1'b1;
        o_wr_n   = 1'b1;
        o_a_d    = 1'b0;
        o_ad_oe  = 1'b0;
        o_ad_out = 8'h00;
        case (r_state)
            PHY_ADR: begin
                o_cs_n   = 1'b0;
                o_wr_n   = 1'b0;
                o_ad_oe  = 1'b1;
                o_ad_out = r_addr;
            end
            PHY_DAT: begin
                o_cs_n = 1'b0;
                o_a_d  = 1'b1;
                if (r_rnw) begin
                    o_rd_n = 1'b0;
                end else begin
                    o_wr_n   = 1'b0;
                    o_ad_oe  = 1'b1;
                    o_ad_out = r_data;
                end
            end
            default: ;
        endcase
    end

    assign o_idle    = (r_state == PHY_IDLE);
    assign o_dat_end = (r_state == PHY_DAT)  && w_phase_end;
    assign o_done    = (r_state == PHY_GAP2) && w_phase_end;

endmodule

// File: rtl/rtc_access_sequencer.sv
// RTC bus master: init writes, periodic 9-register shadow sweep, user writes slotted between sweep reads.
// Decisions made only when the bus PHY is idle; wr_req is held by the requester until the wr_ack pulse.
module rtc_access_sequencer
    import rtc_pkg::*;
#(
    parameter int T_PHASE     = 10,
    parameter int REFRESH_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_req,
    input  logic [3:0]  wr_idx,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a_d,
    output logic [71:0] rtc_regs,
    output logic        sweep_done,
    output logic        busy
);

    localparam int            RW       = $clog2(REFRESH_DIV + 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    sched_state_t  r_sched;
    sched_state_t  w_sched_next;
    logic [RW-1:0] r_ref_cnt;
    logic          r_sweep_act;
    logic          r_sweep_pend;
    logic [3:0]    r_sweep_idx;
    acc_kind_t     r_cur_kind;
    logic [3:0]    r_cur_idx;
    logic          r_wr_ack;
    logic          r_sweep_done;
    logic [71:0]   r_rtc_regs;

    logic          w_idle;
    logic          w_dat_end;
    logic          w_done;
    logic          w_tick;
    logic          w_start;
    logic          w_rnw;
    logic [7:0]    w_addr;
    logic [7:0]    w_data;
    logic          w_grant_sweep;
    logic          w_ack_null;
    acc_kind_t     w_kind;
    logic [3:0]    w_idx;

    rtc_bus_phy #(.T_PHASE(T_PHASE)) u_phy (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_rnw     (w_rnw),
        .i_addr    (w_addr),
        .i_data    (w_data),
        .o_idle    (w_idle),
        .o_dat_end (w_dat_end),
        .o_done    (w_done),
        .o_ad_out  (ad_out),
        .o_ad_oe   (ad_oe),
        .o_cs_n    (cs_n),
        .o_rd_n    (rd_n),
        .o_wr_n    (wr_n),
        .o_a_d     (a_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sched <= SCH_INIT0;
        else          r_sched <= w_sched_next;
    end

    always_comb begin
        w_sched_next = r_sched;
        case (r_sched)
            SCH_INIT0: if (w_done) w_sched_next = SCH_INIT1;
            SCH_INIT1: if (w_done) w_sched_next = SCH_RUN;
            default:               w_sched_next = SCH_RUN;
        endcase
    end

    always_comb begin
        w_start       = 1'b0;
        w_rnw         = 1'b0;
        w_addr        = 8'h00;
        w_data        = 8'h00;
        w_grant_sweep = 1'b0;
        w_ack_null    = 1'b0;
        w_kind        = ACC_INIT;
        w_idx         = IDX_STATUS;
        if (w_idle) begin
            case (r_sched)
                SCH_INIT0: begin
                    w_start = 1'b1;
                    w_addr  = RTC_ADDR[IDX_STATUS];
                    w_data  = INIT_VAL;
                end
                SCH_INIT1: begin
                    w_start = 1'b1;
                    w_addr  = RTC_ADDR[IDX_STATUS];
                    w_data  = ZERO_VAL;
                end
                default: begin
                    // r_wr_ack masks the request still held in the cycle the ack is visible.
                    if (wr_req && !r_wr_ack) begin
                        if (wr_idx > IDX_STATUS) begin
                            w_ack_null = 1'b1;
                        end else begin
                            w_start = 1'b1;
                            w_addr  = RTC_ADDR[wr_idx];
                            w_data  = wr_data;
                            w_kind  = ACC_USER;
                            w_idx   = wr_idx;
                        end
                    end else if (r_sweep_act || r_sweep_pend) begin
                        w_start       = 1'b1;
                        w_rnw         = 1'b1;
                        w_addr        = RTC_ADDR[r_sweep_idx];
                        w_grant_sweep = 1'b1;
                        w_kind        = ACC_SWEEP;
                        w_idx         = r_sweep_idx;
                    end
                end
            endcase
        end
    end

    assign w_tick = (r_sched == SCH_RUN) && (r_ref_cnt == REF_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref_cnt    <= '0;
            r_sweep_act  <= 1'b0;
            r_sweep_pend <= 1'b0;
            r_sweep_idx  <= 4'd0;
            r_cur_kind   <= ACC_INIT;
            r_cur_idx    <= IDX_STATUS;
            r_wr_ack     <= 1'b0;
            r_sweep_done <= 1'b0;
            r_rtc_regs   <= '0;
        end else begin
            r_wr_ack     <= w_ack_null || (w_dat_end && r_cur_kind == ACC_USER);
            r_sweep_done <= w_dat_end && r_cur_kind == ACC_SWEEP && r_cur_idx == IDX_LAST_TIME;

            if (w_start) begin
                r_cur_kind <= w_kind;
                r_cur_idx  <= w_idx;
            end

            if (r_sched != SCH_RUN || w_tick) r_ref_cnt <= '0;
            else                              r_ref_cnt <= r_ref_cnt + 1'b1;

            // A tick that lands while a sweep is running is simply lost.
            if (w_grant_sweep)                  r_sweep_pend <= 1'b0;
            else if (w_tick && !r_sweep_act)    r_sweep_pend <= 1'b1;

            if (w_grant_sweep) r_sweep_act <= 1'b1;

            if (w_dat_end && r_cur_kind == ACC_SWEEP) begin
                if (r_cur_idx == IDX_LAST_TIME) begin
                    r_sweep_act <= 1'b0;
                    r_sweep_idx <= 4'd0;
                end else begin
                    r_sweep_idx <= r_sweep_idx + 1'b1;
                end
            end

            if (w_dat_end && r_cur_idx <= IDX_LAST_TIME) begin
                if (r_cur_kind == ACC_SWEEP)
                    r_rtc_regs[{r_cur_idx, 3'b000} +: 8] <= ad_in;
                else if (r_cur_kind == ACC_USER)
                    r_rtc_regs[{r_cur_idx, 3'b000} +: 8] <= wr_data;
            end
        end
    end

    assign wr_ack     = r_wr_ack;
    assign sweep_done = r_sweep_done;
    assign rtc_regs   = r_rtc_regs;
    assign busy       = !w_idle;

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Scoreboarded bench: expected bus accesses and shadow contents are queued by the stimulus, checked by monitors.
// A second instance with a short refresh period checks that sweeps never overlap.
module tb_rtc_access_sequencer;

    localparam int TP = 2;
    localparam logic [7:0]  ADDR_TBL [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    localparam logic [71:0] REGS_PLAIN = 72'h38_37_36_35_34_33_32_31_30;

    logic        clk;
    logic        reset_n, reset2_n;
    logic        wr_req;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_ack2;
    logic [7:0]  ad_in, ad_in2, ad_out, ad_out2;
    logic        ad_oe, ad_oe2, cs_n, cs_n2, rd_n, rd_n2, wr_n, wr_n2, a_d, a_d2;
    logic [71:0] rtc_regs, rtc_regs2;
    logic        sweep_done, sweep_done2, busy, busy2;
    logic        wr_req2;
    logic [3:0]  wr_idx2;
    logic [7:0]  wr_data2;

    rtc_access_sequencer #(.T_PHASE(TP), .REFRESH_DIV(200)) dut (
        .clk(clk), .reset_n(reset_n), .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_ack(wr_ack), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .rtc_regs(rtc_regs), .sweep_done(sweep_done),
        .busy(busy)
    );

    rtc_access_sequencer #(.T_PHASE(TP), .REFRESH_DIV(20)) dut2 (
        .clk(clk), .reset_n(reset2_n), .wr_req(wr_req2), .wr_idx(wr_idx2), .wr_data(wr_data2),
        .wr_ack(wr_ack2), .ad_in(ad_in2), .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2),
        .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2), .rtc_regs(rtc_regs2), .sweep_done(sweep_done2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC model: remembers the last address phase, answers reads with 8'h30 + table index.
    logic [7:0] bus_addr = 8'h00, bus_addr2 = 8'h00;
    always @(posedge clk) if (!cs_n  && !a_d)  bus_addr  <= ad_out;
    always @(posedge clk) if (!cs_n2 && !a_d2) bus_addr2 <= ad_out2;

    function automatic logic [7:0] resp(input logic [7:0] a);
        for (int i = 0; i < 9; i++) if (ADDR_TBL[i] == a) return 8'h30 + 8'(i);
        return 8'hEE;
    endfunction

    assign ad_in  = rd_n  ? 8'h00 : resp(bus_addr);
    assign ad_in2 = rd_n2 ? 8'h00 : resp(bus_addr2);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_empty(input string name, input logic [71:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected nothing queued", name, got);
    endtask

    logic [16:0] exp_acc [$];
    logic [71:0] exp_regs [$];

    task automatic push_acc(input logic rd, input logic [7:0] addr, input logic [7:0] data);
        exp_acc.push_back({rd, addr, data});
    endtask

    task automatic push_reads(input int first, input int last);
        for (int i = first; i <= last; i++) push_acc(1'b1, ADDR_TBL[i], 8'h00);
    endtask

    // Monitor for the main instance.
    logic        prev_cs = 1'b1;
    int          run_len = 0;
    int          n_acc = 0;
    logic [7:0]  mon_addr = 8'h00;
    logic        mon_ok;
    logic [16:0] mon_got;

    always @(negedge clk) begin
        if (reset_n) begin
            if (cs_n)      mon_ok = rd_n && wr_n && !ad_oe;
            else if (!a_d) mon_ok = !wr_n && rd_n && ad_oe;
            else           mon_ok = (rd_n != wr_n) && (ad_oe == rd_n);
            check("bus_proto", 72'(mon_ok), 72'(1'b1));
            if (!cs_n) begin
                run_len++;
                if (prev_cs) begin
                    if (!a_d) begin
                        mon_addr = ad_out;
                    end else begin
                        n_acc++;
                        mon_got = {~rd_n, mon_addr, rd_n ? ad_out : 8'h00};
                        if (exp_acc.size() == 0) fail_empty("bus_access", 72'(mon_got));
                        else check("bus_access", 72'(mon_got), 72'(exp_acc.pop_front()));
                    end
                end
            end else if (!prev_cs) begin
                check("phase_len", 72'(run_len), 72'(TP));
                run_len = 0;
            end
            if (sweep_done) begin
                if (exp_regs.size() == 0) fail_empty("sweep_regs", rtc_regs);
                else check("sweep_regs", rtc_regs, exp_regs.pop_front());
            end
            prev_cs = cs_n;
        end else begin
            prev_cs = 1'b1;
            run_len = 0;
        end
    end

    // Monitor for the short-refresh instance: reads must always walk the table in order.
    logic       prev_cs2 = 1'b1;
    int         nxt2 = 0;
    logic [7:0] mon_addr2 = 8'h00;

    always @(negedge clk) begin
        if (reset2_n) begin
            if (!cs_n2 && prev_cs2) begin
                if (!a_d2) begin
                    mon_addr2 = ad_out2;
                end else if (!rd_n2) begin
                    check("sweep2_order", 72'(mon_addr2), 72'(ADDR_TBL[nxt2]));
                    nxt2 = (nxt2 == 8) ? 0 : nxt2 + 1;
                end
            end
            if (sweep_done2) begin
                check("sweep2_done_pos", 72'(nxt2), 72'(0));
                check("sweep2_regs", rtc_regs2, REGS_PLAIN);
            end
            prev_cs2 = cs_n2;
        end
    end

    int base_acc;
    int cs_low;

    initial begin
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        wr_req   = 1'b0;
        wr_idx   = 4'd0;
        wr_data  = 8'h00;
        wr_req2  = 1'b0;
        wr_idx2  = 4'd0;
        wr_data2 = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_strobes", 72'({cs_n, rd_n, wr_n, a_d}), 72'(4'b1110));
        check("rst_bus_drive", 72'({ad_oe, ad_out}), 72'(9'h000));
        check("rst_flags", 72'({wr_ack, sweep_done, busy}), 72'(3'b000));
        check("rst_regs", rtc_regs, 72'h0);

        push_acc(1'b0, 8'h02, 8'h10);
        push_acc(1'b0, 8'h02, 8'h00);
        push_reads(0, 8);
        exp_regs.push_back(REGS_PLAIN);
        reset_n  = 1'b1;
        reset2_n = 1'b1;

        for (int i = 0; i < 600 && !sweep_done; i++) @(negedge clk);
        check("sweep1_seen", 72'(sweep_done), 72'(1'b1));

        // Second sweep with a user write injected during the read of index 3.
        push_reads(0, 3);
        for (int i = 0; i < 400 && !(!cs_n && !a_d && ad_out == 8'h24); i++) @(negedge clk);
        check("adr_idx3_seen", 72'(ad_out), 72'(8'h24));
        push_acc(1'b0, 8'h22, 8'h45);
        push_reads(4, 8);
        exp_regs.push_back(72'h38_37_36_35_34_33_32_45_30);
        wr_idx  = 4'd1;
        wr_data = 8'h45;
        wr_req  = 1'b1;
        for (int i = 0; i < 60 && !wr_ack; i++) @(negedge clk);
        check("wr_ack_mid_sweep", 72'(wr_ack), 72'(1'b1));
        check("regs_slot1_at_ack", 72'(rtc_regs[15:8]), 72'(8'h45));
        wr_req = 1'b0;
        for (int i = 0; i < 200 && !sweep_done; i++) @(negedge clk);
        check("sweep2_seen", 72'(sweep_done), 72'(1'b1));

        // Third sweep is cut by reset in the data phase of its first read.
        push_reads(0, 8);
        for (int i = 0; i < 400 && rd_n; i++) @(negedge clk);
        check("read_dat_seen", 72'(rd_n), 72'(1'b0));
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_strobes", 72'({cs_n, rd_n, wr_n}), 72'(3'b111));
        check("abort_regs", rtc_regs, 72'h0);
        check("abort_busy", 72'(busy), 72'(1'b0));
        exp_acc.delete();
        repeat (3) @(negedge clk);

        // User write requested during INIT0 must wait for both init writes.
        push_acc(1'b0, 8'h02, 8'h10);
        push_acc(1'b0, 8'h02, 8'h00);
        push_acc(1'b0, 8'h23, 8'h5A);
        base_acc = n_acc;
        reset_n  = 1'b1;
        wr_idx   = 4'd2;
        wr_data  = 8'h5A;
        wr_req   = 1'b1;
        for (int i = 0; i < 100 && !wr_ack; i++) @(negedge clk);
        check("held_wr_ack_seen", 72'(wr_ack), 72'(1'b1));
        check("accesses_before_ack", 72'(n_acc - base_acc), 72'(3));
        check("regs_after_held_wr", rtc_regs, 72'h00_00_00_00_00_00_5A_00_00);
        wr_req = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("idle_after_wr", 72'(busy), 72'(1'b0));

        // Out-of-table index: acknowledged without touching the bus.
        wr_idx  = 4'd12;
        wr_data = 8'h77;
        wr_req  = 1'b1;
        cs_low  = 0;
        for (int i = 0; i < 10 && !wr_ack; i++) begin
            @(negedge clk);
            if (!cs_n) cs_low++;
        end
        check("null_wr_ack_seen", 72'(wr_ack), 72'(1'b1));
        check("null_wr_no_bus", 72'(cs_low), 72'(0));
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("null_wr_quiet", 72'({wr_ack, cs_n, busy}), 72'(3'b010));
        check("regs_unchanged", rtc_regs, 72'h00_00_00_00_00_00_5A_00_00);
        check("exp_acc_drained", 72'(exp_acc.size()), 72'(0));
        check("exp_regs_drained", 72'(exp_regs.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
